// File: rtl/abp_pkg.sv
// Shared definitions for the ABP receive-side controller.
// ACK framing constants and the controller state type.
package abp_pkg;

    localparam logic [7:0] ACK_MAGIC = 8'hAC;
    localparam int         ACK_LEN   = 2;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        DELIVER = 4'd1,
        ACK_HDR = 4'd2,
        ACK_SEQ = 4'd3,
        RELEASE = 4'd4
    } abp_rx_ctrl_state_t;

endpackage

// File: rtl/abp_sat_counter.sv
// Saturating event counter with registered output.
// Holds at all-ones instead of wrapping.
module abp_sat_counter #(
    parameter int W = 16
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: bump on inc unless already saturated
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/abp_receiver_ctrl.sv
// Receive-side ABP sequencer: delivers new payloads, ACKs every
// packet on AXI-Stream, releases the receiver, aborts stalled packets.
module abp_receiver_ctrl
    import abp_pkg::*;
#(
    parameter int RX_TIMEOUT = 1024,
    parameter int CNT_W      = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             rx_busy,
    input  logic             rx_done,
    input  logic [63:0]      rx_value,
    input  logic             rx_seq,
    output logic             expected_bit,
    output logic             rx_release,
    output logic             rx_abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tlast,
    output logic [CNT_W-1:0] accept_cnt,
    output logic [CNT_W-1:0] dup_cnt,
    output logic [CNT_W-1:0] abort_cnt
);

    localparam int WD_W = $clog2(RX_TIMEOUT + 1);

    abp_rx_ctrl_state_t state_q, state_d;
    logic            exp_q, exp_d;
    logic            seq_q, seq_d;
    logic            new_q, new_d;
    logic [63:0]     data_q, data_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            rel_q, rel_d;
    logic            abt_q, abt_d;
    logic            ov_q, ov_d;
    logic            tv_q, tv_d;
    logic [7:0]      td_q, td_d;
    logic            tl_q, tl_d;
    logic            inc_acc, inc_dup, inc_abt;

    // Sequencing, watchdog and next-cycle output values
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        seq_d   = seq_q;
        new_d   = new_q;
        data_d  = data_q;
        wd_d    = '0;
        abt_d   = 1'b0;
        inc_acc = 1'b0;
        inc_dup = 1'b0;
        inc_abt = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx_done) begin
                    data_d  = rx_value;
                    seq_d   = rx_seq;
                    new_d   = (rx_seq == exp_q);
                    state_d = (rx_seq == exp_q) ? DELIVER : ACK_HDR;
                end else if (wd_q == WD_W'(RX_TIMEOUT)) begin
                    abt_d   = 1'b1;
                    inc_abt = 1'b1;
                end else if (rx_busy) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            DELIVER: begin
                if (out_ready) state_d = ACK_HDR;
            end
            ACK_HDR: begin
                if (m_axis_tready) state_d = ACK_SEQ;
            end
            ACK_SEQ: begin
                if (m_axis_tready) begin
                    state_d = RELEASE;
                    if (new_q) begin
                        exp_d   = ~exp_q;
                        inc_acc = 1'b1;
                    end else begin
                        inc_dup = 1'b1;
                    end
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ov_d  = (state_d == DELIVER);
        tv_d  = (state_d == ACK_HDR) || (state_d == ACK_SEQ);
        tl_d  = (state_d == ACK_SEQ);
        rel_d = (state_d == RELEASE);
        td_d  = 8'h00;
        if (state_d == ACK_HDR) td_d = ACK_MAGIC;
        if (state_d == ACK_SEQ) td_d = {7'b0, seq_d};
    end

    // State and registered outputs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            exp_q   <= 1'b0;
            seq_q   <= 1'b0;
            new_q   <= 1'b0;
            data_q  <= '0;
            wd_q    <= '0;
            rel_q   <= 1'b0;
            abt_q   <= 1'b0;
            ov_q    <= 1'b0;
            tv_q    <= 1'b0;
            td_q    <= '0;
            tl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            seq_q   <= seq_d;
            new_q   <= new_d;
            data_q  <= data_d;
            wd_q    <= wd_d;
            rel_q   <= rel_d;
            abt_q   <= abt_d;
            ov_q    <= ov_d;
            tv_q    <= tv_d;
            td_q    <= td_d;
            tl_q    <= tl_d;
        end
    end

    abp_sat_counter #(.W(CNT_W)) u_acc (
        .aclk    (aclk),
        .aresetn (aresetn),
        .inc     (inc_acc),
        .count   (accept_cnt)
    );

    abp_sat_counter #(.W(CNT_W)) u_dup (
        .aclk    (aclk),
        .aresetn (aresetn),
        .inc     (inc_dup),
        .count   (dup_cnt)
    );

    abp_sat_counter #(.W(CNT_W)) u_abt (
        .aclk    (aclk),
        .aresetn (aresetn),
        .inc     (inc_abt),
        .count   (abort_cnt)
    );

    assign expected_bit  = exp_q;
    assign rx_release    = rel_q;
    assign rx_abort      = abt_q;
    assign out_valid     = ov_q;
    assign out_data      = data_q;
    assign m_axis_tvalid = tv_q;
    assign m_axis_tdata  = td_q;
    assign m_axis_tlast  = tl_q;

endmodule
